// File: rtl/alu_pkg.sv
// Shared ALUControl code constants and exec-stage FSM encoding.
// Used by the ALU-control decoder, alu_core and alu_exec_stage.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b111;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

  function automatic logic is_shift_op(input logic [2:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath. Shift codes pass src_a through unless FAST_SHIFT_EN
// is defined, in which case they use a full barrel shifter.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = src_a + src_b;
    case (alu_control)
      ALU_SUB: result = src_a + ~src_b + WIDTH'(1);
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_XOR: result = src_a ^ src_b;
`ifdef FAST_SHIFT_EN
      ALU_SLL: result = src_a << src_b[SHW-1:0];
      ALU_SRL: result = src_a >> src_b[SHW-1:0];
`else
      // Iterative build: this path only serves shamt == 0.
      ALU_SLL: result = src_a;
      ALU_SRL: result = src_a;
`endif
      default: result = src_a + src_b;  // ADD and the 011 alias
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with valid/ready handshake and a one-entry result register.
// Shifts iterate one bit per cycle unless FAST_SHIFT_EN selects the single-cycle barrel shifter.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

`ifdef FAST_SHIFT_EN
  localparam bit FastShift = 1'b1;
`else
  localparam bit FastShift = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             srl_q, srl_d;
  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] shifted;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             start_shift;

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_alu_core (
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .result      (core_result)
  );

  assign shamt       = src_b[SHW-1:0];
  assign accept      = in_valid && in_ready;
  assign start_shift = !FastShift && accept && is_shift_op(alu_control) && (shamt != '0);
  assign shifted     = srl_q ? {1'b0, work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_shift) state_d = StShift;
      StShift: if (cnt_q == SHW'(1)) state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = (state_q == StShift);
    in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  end

  // Datapath next state
  always_comb begin
    work_d      = work_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    srl_d       = srl_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (state_q == StShift) begin
      // Output register is guaranteed empty here; entry required it free or draining.
      work_d = shifted;
      cnt_d  = cnt_q - SHW'(1);
      if (cnt_q == SHW'(1)) begin
        result_d    = shifted;
        out_valid_d = 1'b1;
      end
    end else if (accept) begin
      if (start_shift) begin
        work_d = src_a;
        cnt_d  = shamt;
        srl_d  = (alu_control == ALU_SRL);
      end else begin
        result_d    = core_result;
        out_valid_d = 1'b1;
      end
    end
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      srl_q       <= 1'b0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      work_q      <= work_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      srl_q       <= srl_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule
